max_pooling: RTL and testbench



---
 rtl/maxpool_pkg.sv | 26 ++
 rtl/maxpool_line_buf.sv | 32 +++
 rtl/max_pooling.sv | 108 ++++++++++
 tb/tb_max_pooling.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/maxpool_pkg.sv
// Shared types and geometry for the 2x2 stride-2 max-pooling stage.
package maxpool_pkg;
    localparam int DATA_W = 16;
    localparam int IMG_W  = 28;
    localparam int IMG_H  = 28;
    localparam int NUM_CH = 5;

    localparam int COL_W     = $clog2(IMG_W);
    localparam int ROW_W     = $clog2(IMG_H);
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int BUF_DEPTH = IMG_W / 2;
    localparam int BUF_AW    = COL_W - 1;

    typedef logic signed [DATA_W-1:0] pixel_t;
    typedef logic [COL_W-1:0]         col_t;
    typedef logic [ROW_W-1:0]         row_t;
    typedef logic [CH_W-1:0]          ch_t;

    localparam col_t COL_LAST = col_t'(IMG_W - 1);
    localparam row_t ROW_LAST = row_t'(IMG_H - 1);
    localparam ch_t  CH_LAST  = ch_t'(NUM_CH - 1);

    function automatic pixel_t pix_max(input pixel_t a, input pixel_t b);
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/maxpool_line_buf.sv
// Holds the horizontal pair maxima of the current even row, one entry per output column.
module maxpool_line_buf
    import maxpool_pkg::*;
#(
    parameter int DEPTH = BUF_DEPTH,
    parameter int AW    = BUF_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  pixel_t        wdata,
    output pixel_t        rdata
);
    pixel_t rd_arr [DEPTH];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        pixel_t entry_reg;

        always_ff @(posedge clk) begin
            if (rst) begin
                entry_reg <= '0;
            end else if (we && (addr == AW'(gi))) begin
                entry_reg <= wdata;
            end
        end

        assign rd_arr[gi] = entry_reg;
    end

    assign rdata = rd_arr[addr];
endmodule

// File: rtl/max_pooling.sv
// Streaming 2x2 stride-2 max pooling: position counters, pair/quad comparators and
// a registered result with regenerated frame/line markers.
module max_pooling
    import maxpool_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   ena,
    input  logic   frame_start_in,
    input  logic   line_start_in,
    input  logic   frame_end_in,
    input  pixel_t sig_layer,
    output pixel_t max_layer,
    output logic   valid,
    output logic   frame_start_out,
    output logic   line_start_out,
    output logic   frame_end_out
);
    col_t   col_reg, col_cur, col_next;
    row_t   row_reg, row_cur, row_next;
    ch_t    ch_reg, ch_cur, ch_next;
    pixel_t prev_reg;
    pixel_t buf_rdata, pair_max, quad_max;
    logic   col_last, row_last, ch_last, frame_last;
    logic   buf_we, result_en;

    // Positioning is purely counter-based; the incoming markers carry no extra information.
    logic unused_markers;
    assign unused_markers = line_start_in ^ frame_end_in;

    // A frame start in the same cycle as a pixel makes that pixel position (0,0,0).
    always_comb begin
        col_cur = frame_start_in ? '0 : col_reg;
        row_cur = frame_start_in ? '0 : row_reg;
        ch_cur  = frame_start_in ? '0 : ch_reg;
    end

    assign col_last   = (col_cur == COL_LAST);
    assign row_last   = (row_cur == ROW_LAST);
    assign ch_last    = (ch_cur == CH_LAST);
    assign frame_last = col_last & row_last & ch_last;

    always_comb begin
        col_next = col_cur + col_t'(1);
        row_next = row_cur;
        ch_next  = ch_cur;
        if (col_last) begin
            col_next = '0;
            row_next = row_cur + row_t'(1);
            if (row_last) begin
                row_next = '0;
                ch_next  = ch_last ? '0 : ch_cur + ch_t'(1);
            end
        end
    end

    assign pair_max  = pix_max(prev_reg, sig_layer);
    assign quad_max  = pix_max(buf_rdata, pair_max);
    assign buf_we    = ena & col_cur[0] & ~row_cur[0];
    assign result_en = ena & col_cur[0] & row_cur[0];

    maxpool_line_buf #(
        .DEPTH(BUF_DEPTH),
        .AW   (BUF_AW)
    ) u_line_buf (
        .clk  (clk),
        .rst  (rst),
        .we   (buf_we),
        .addr (col_cur[COL_W-1:1]),
        .wdata(pair_max),
        .rdata(buf_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            col_reg         <= '0;
            row_reg         <= '0;
            ch_reg          <= '0;
            prev_reg        <= '0;
            max_layer       <= '0;
            valid           <= 1'b0;
            frame_start_out <= 1'b0;
            line_start_out  <= 1'b0;
            frame_end_out   <= 1'b0;
        end else begin
            valid           <= 1'b0;
            line_start_out  <= 1'b0;
            frame_end_out   <= 1'b0;
            frame_start_out <= frame_start_in;
            if (ena) begin
                prev_reg <= sig_layer;
                col_reg  <= col_next;
                row_reg  <= row_next;
                ch_reg   <= ch_next;
            end else if (frame_start_in) begin
                col_reg <= '0;
                row_reg <= '0;
                ch_reg  <= '0;
            end
            if (result_en) begin
                max_layer      <= quad_max;
                valid          <= 1'b1;
                line_start_out <= col_last & ~frame_last;
                frame_end_out  <= frame_last;
            end
        end
    end
endmodule

// File: tb/tb_max_pooling.sv
// Randomized and patterned frames checked against a whole-frame pooling model.
module tb_max_pooling;
    import maxpool_pkg::*;

    localparam int W = IMG_W;
    localparam int H = IMG_H;
    localparam int C = NUM_CH;
    localparam int N = C * H * W;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    logic   ena = 1'b0;
    logic   fsi = 1'b0;
    logic   lsi = 1'b0;
    logic   fei = 1'b0;
    pixel_t sig = '0;
    pixel_t max_layer;
    logic   valid, fso, lso, feo;

    always #5 clk = ~clk;

    max_pooling dut (
        .clk            (clk),
        .rst            (rst),
        .ena            (ena),
        .frame_start_in (fsi),
        .line_start_in  (lsi),
        .frame_end_in   (fei),
        .sig_layer      (sig),
        .max_layer      (max_layer),
        .valid          (valid),
        .frame_start_out(fso),
        .line_start_out (lso),
        .frame_end_out  (feo)
    );

    typedef struct {
        int val;
        bit ls;
        bit fe;
    } res_t;

    res_t expq[$];
    int   pix[N];
    int   total = 0;
    int   bad = 0;
    bit   chk_en = 1'b0;
    int   n_valid, n_ls, n_fe;
    logic fs_samp = 1'b0;

    always @(posedge clk) fs_samp <= rst ? 1'b0 : fsi;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Expected results for a frame of which only the first n pixels are delivered.
    function automatic void build_expected(input int n);
        for (int u = 0; u < C; u++)
            for (int i = 0; i < H / 2; i++)
                for (int j = 0; j < W / 2; j++) begin
                    int base = u * H * W + 2 * i * W + 2 * j;
                    res_t e;
                    if (base + W + 1 < n) begin
                        e.val = max2(max2(pix[base], pix[base + 1]),
                                     max2(pix[base + W], pix[base + W + 1]));
                        e.fe  = (u == C - 1) && (i == H / 2 - 1) && (j == W / 2 - 1);
                        e.ls  = (j == W / 2 - 1) && !e.fe;
                        expq.push_back(e);
                    end
                end
    endfunction

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            total++;
            if (fso !== fs_samp) begin
                bad++;
                $display("FAIL frame_start_out got=%0b want=%0b", fso, fs_samp);
            end
            if (valid === 1'b1) begin
                res_t e;
                n_valid++;
                if (lso) n_ls++;
                if (feo) n_fe++;
                total++;
                if (expq.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_valid got=%0d want=none", int'(max_layer));
                end else begin
                    e = expq.pop_front();
                    if (int'(max_layer) != e.val || lso !== e.ls || feo !== e.fe) begin
                        bad++;
                        $display("FAIL result got=%0d ls=%0b fe=%0b want=%0d ls=%0b fe=%0b",
                                 int'(max_layer), lso, feo, e.val, e.ls, e.fe);
                    end
                end
            end else begin
                total++;
                if (valid !== 1'b0 || lso !== 1'b0 || feo !== 1'b0) begin
                    bad++;
                    $display("FAIL idle_markers got=v%0b ls%0b fe%0b want=000", valid, lso, feo);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            ena = 1'b0; fsi = 1'b0; lsi = 1'b0; fei = 1'b0;
        end
    endtask

    task automatic drive_frame(input int n, input bit gaps);
        build_expected(n);
        for (int k = 0; k < n; k++) begin
            if (gaps) idle($urandom_range(0, 3));
            @(posedge clk);
            #1;
            ena = 1'b1;
            fsi = (k == 0);
            lsi = (k % W == W - 1);
            fei = (k == N - 1);
            sig = pixel_t'(pix[k]);
        end
        idle(1);
    endtask

    task automatic clear_counts();
        n_valid = 0; n_ls = 0; n_fe = 0;
    endtask

    task automatic fill_random();
        for (int k = 0; k < N; k++) pix[k] = int'($urandom_range(0, 65535)) - 32768;
    endtask

    initial begin
        clear_counts();
        idle(3);
        rst = 1'b0;
        #2;
        check("reset_max_layer", int'(max_layer), 0);
        check("reset_valid", int'(valid), 0);
        check("reset_markers", int'({fso, lso, feo}), 0);
        chk_en = 1'b1;

        // Ramp, contiguous
        for (int k = 0; k < N; k++)
            pix[k] = (k / (H * W)) * 1000 + ((k / W) % H) * 28 + (k % W);
        build_expected(N);
        check("model_ramp_first", expq[0].val, 29);
        check("model_ramp_last", expq[$].val, 4783);
        check("model_ramp_size", expq.size(), 980);
        expq.delete();
        clear_counts();
        drive_frame(N, 1'b0);
        idle(3);
        check("ramp_valid_count", n_valid, 980);
        check("ramp_line_start_count", n_ls, 69);
        check("ramp_frame_end_count", n_fe, 1);
        $display("ramp frame: results=%0d line_starts=%0d", n_valid, n_ls);

        // All negative, with random gaps
        for (int k = 0; k < N; k++) pix[k] = -(((k / W) % H) * 28 + (k % W)) - 1;
        build_expected(N);
        check("model_neg_first", expq[0].val, -1);
        check("model_neg_second", expq[1].val, -3);
        expq.delete();
        clear_counts();
        drive_frame(N, 1'b1);
        idle(3);
        check("neg_gap_line_start_count", n_ls, 69);
        $display("negative frame with gaps: results=%0d", n_valid);

        // Maximum in each quadrant position of the first window
        for (int q = 0; q < 4; q++) begin
            for (int k = 0; k < N; k++) pix[k] = -32768;
            pix[(q / 2) * W + (q % 2)] = 32767;
            build_expected(N);
            check("model_quad_hit", expq[0].val, 32767);
            check("model_quad_other", expq[1].val, -32768);
            expq.delete();
            drive_frame(N, 1'b0);
            idle(2);
            $display("quadrant %0d frame done", q);
        end

        // Random data with gaps
        fill_random();
        clear_counts();
        drive_frame(N, 1'b1);
        idle(3);
        check("rand_valid_count", n_valid, 980);
        check("rand_line_start_count", n_ls, 69);
        $display("random frame with gaps: results=%0d", n_valid);

        // Reset at pixel 400, then a full new frame
        fill_random();
        drive_frame(400, 1'b0);
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        check("reset_queue_drained", expq.size(), 0);
        clear_counts();
        idle(5);
        check("no_output_after_reset", n_valid, 0);
        fill_random();
        drive_frame(N, 1'b0);
        idle(3);
        check("post_reset_valid_count", n_valid, 980);
        $display("reset mid-frame then new frame: results=%0d", n_valid);

        // Frame restarted mid-way by a new frame start
        fill_random();
        drive_frame(500, 1'b0);
        fill_random();
        clear_counts();
        drive_frame(N, 1'b1);
        idle(3);
        check("restart_frame_end_count", n_fe, 1);
        $display("mid-frame restart: results=%0d", n_valid);

        // Two back-to-back frames
        clear_counts();
        fill_random();
        drive_frame(N, 1'b0);
        fill_random();
        drive_frame(N, 1'b0);
        idle(3);
        check("b2b_valid_count", n_valid, 1960);
        check("b2b_frame_end_count", n_fe, 2);
        $display("back-to-back frames: results=%0d frame_ends=%0d", n_valid, n_fe);

        check("final_queue_empty", expq.size(), 0);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
